// File: rtl/aes_pkg.sv
// Shared types and constants for the byte-serial AES SubBytes datapath.
// Also holds the GF(2^8) multiply used by the S-box.
package aes_pkg;

  localparam int NUM_BYTES_DEF = 16;

  typedef logic [127:0] state128_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/sbytes.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Purely combinational; one instance serves the whole byte-serial datapath.
module sbytes
  import aes_pkg::*;
(
  input  logic [7:0] olddata,
  output logic [7:0] newdata
);

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  always_comb begin
    x2   = gf_mul(olddata, olddata);
    x3   = gf_mul(x2, olddata);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, olddata);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, olddata);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, olddata);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, olddata);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, olddata);
    inv  = gf_mul(x127, x127);
  end

  assign newdata = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/sub_bytes_seq.sv
// Byte-serial SubBytes: one S-box walks the state buffer one byte per cycle.
//   state   | meaning
//   IDLE    | ready for a new block, no result held
//   SUB     | substituting byte cnt of the buffer
//   DONE    | result held on out_state until out_ready
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_state,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_state,
  output logic                   busy
);

  localparam int SW = 8 * NUM_BYTES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

  sub_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    buf_q, buf_d;
  logic [7:0]       sb_old, sb_new;

  // Byte 0 sits in the MSB position of the buffer.
  assign sb_old = buf_q[SW-1-8*int'(cnt_q) -: 8];

  sbytes u_sbytes (
    .olddata (sb_old),
    .newdata (sb_new)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          buf_d   = in_state;
          cnt_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        buf_d[SW-1-8*int'(cnt_q) -: 8] = sb_new;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort wins over everything; the partially substituted buffer is kept.
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      buf_d   = buf_q;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SUB);
  assign out_state = buf_q;

  a_cnt_range: assert property (@(posedge clk) disable iff (!n_rst)
    int'(cnt_q) < NUM_BYTES);

  a_done_hold: assert property (@(posedge clk) disable iff (!n_rst)
    (state_q == ST_DONE && !out_ready && !clear) |=> (state_q == ST_DONE && $stable(buf_q)));

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: expected blocks are queued on acceptance
// and compared when the result is handed off.
module tb_sub_bytes_seq;

  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            clear = 1'b0;
  logic            out_ready = 1'b1;
  logic [8*NB-1:0] in_state = '0;
  logic            in_ready, out_valid, busy;
  logic [8*NB-1:0] out_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic [127:0] sb_q[$];
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_seq #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box: brute-force inverse search plus affine map.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r ^= t;
      t = t[7] ? ((t << 1) ^ 8'h1b) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int c = 1; c < 256; c++)
      if (v != 8'h00 && ref_mul(v, 8'(c)) == 8'h01) inv = 8'(c);
    s = 8'h63;
    for (int r = 0; r < 5; r++) s ^= (inv << r) | (inv >> (8 - r));
    return s;
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] d);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = ref_sbox(d[8*k +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Result monitor: a handoff happens at the edge after a cycle with valid & ready.
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) chk("latency", 128'(cyc - accept_cyc), 128'(16));
      prev_ov = out_valid;
      if (out_valid && out_ready && !clear) begin
        if (sb_q.size() == 0) chk("spurious_out", 128'(out_valid), 128'(0));
        else chk("out_state", out_state, sb_q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves in_valid high; caller lowers it (or reuses it for back-to-back).
  task automatic send(input logic [127:0] d, input logic [127:0] exp);
    int w = 0;
    in_state = d;
    in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    step();
    accept_cyc = cyc;
    sb_q.push_back(exp);
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (sb_q.size() != 0 && w < 60) begin
      step();
      w++;
    end
    chk(tag, 128'(sb_q.size()), 128'(0));
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      step();
      seen |= out_valid;
    end
    chk(tag, 128'(seen), 128'(0));
  endtask

  initial begin
    logic [127:0] d, e, ka, kb;
    logic [7:0] pat_in[5];
    logic [7:0] pat_out[5];
    int ca, cb, w;
    pat_in  = '{8'h43, 8'h00, 8'hFF, 8'h74, 8'h61};
    pat_out = '{8'h1A, 8'h63, 8'h16, 8'h92, 8'hEF};

    // Reset values
    step(3);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    n_rst = 1'b1;
    step(2);

    // All-zero block
    send(128'h0, {16{8'h63}});
    in_valid = 1'b0;
    chk("sub_busy", 128'(busy), 128'(1));
    chk("sub_in_ready", 128'(in_ready), 128'(0));
    drain("drain_zero");

    // Known vector, byte positions preserved
    for (int i = 0; i < 16; i++) begin
      d[127-8*i -: 8] = pat_in[i % 5];
      e[127-8*i -: 8] = pat_out[i % 5];
    end
    send(d, e);
    in_valid = 1'b0;
    drain("drain_known");

    // Random blocks against the reference model
    for (int i = 0; i < 3; i++) begin
      d = rand_block();
      send(d, ref_block(d));
      in_valid = 1'b0;
      drain("drain_rand");
    end

    // Backpressure in DONE; a stray in_valid must be ignored
    out_ready = 1'b0;
    d = rand_block();
    e = ref_block(d);
    send(d, e);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      step();
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_state", out_state, e);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      if (i == 2) begin
        in_state = rand_block();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_idle_ready", 128'(in_ready), 128'(1));
    chk("bp_idle_ov", 128'(out_valid), 128'(0));
    chk("bp_sb_empty", 128'(sb_q.size()), 128'(0));
    quiet("bp_no_extra", 20);

    // clear beats in_valid in IDLE
    in_state = rand_block();
    in_valid = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_prio_busy", 128'(busy), 128'(0));
    chk("clr_prio_ready", 128'(in_ready), 128'(1));

    // Abort at cnt == 7, then an all-FF block
    d = rand_block();
    send(d, ref_block(d));
    in_valid = 1'b0;
    step(7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    sb_q.delete();
    chk("abort_ready", 128'(in_ready), 128'(1));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_ov", 128'(out_valid), 128'(0));
    quiet("abort_quiet", 20);
    send({16{8'hFF}}, {16{8'h16}});
    in_valid = 1'b0;
    drain("drain_ff");

    // Asynchronous reset mid-SUB
    d = rand_block();
    send(d, ref_block(d));
    in_valid = 1'b0;
    step(5);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_ready", 128'(in_ready), 128'(1));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_out_state", out_state, 128'(0));
    sb_q.delete();
    step(2);
    n_rst = 1'b1;
    quiet("arst_quiet", 24);

    // Back-to-back blocks with out_ready tied high
    ka = rand_block();
    kb = rand_block();
    send(ka, ref_block(ka));
    ca = accept_cyc;
    send(kb, ref_block(kb));
    cb = accept_cyc;
    in_valid = 1'b0;
    chk("b2b_interval", 128'(cb - ca), 128'(18));
    drain("drain_b2b");
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
